hotkey_ctrl: RTL and testbench
==============================

Name: hotkey_ctrl

Overview:
- Watches decoded joypad scans and matches them against the save, load and menu hotkey masks held in the system config bank.
- Runs a hold-qualify / request / acknowledge / release sequence for each hotkey.
- Raises a single request to the MCU-side service logic and waits for the acknowledge.
- Sits between the joypad scanner and the PI service path; it also drives a pad-block signal so the console does not see the combo while a request is being serviced.

Parameters:
HOLD_SCANS, 4, consecutive matching scans required before a request fires (1..255)
ACK_TMO, 24'd1000000, clk cycles to wait for req_ack before abandoning the request
CODE_W, 2, width of the request code

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
pad_val  in  8  current button state, active-high, valid when pad_strobe=1
pad_strobe  in  1  one-cycle pulse per completed pad scan
key_save  in  8  save hotkey mask (0 = disabled)
key_load  in  8  load hotkey mask (0 = disabled)
key_menu  in  8  menu hotkey mask (0 = disabled)
sst_on  in  1  save-state feature enable; gates save and load
req_valid  out  1  request pending toward MCU
req_code  out  CODE_W  1 = menu, 2 = save, 3 = load, 0 = none
req_ack  in  1  one-cycle acknowledge from MCU
req_tmo  out  1  one-cycle pulse when a request times out
pad_block  out  1  high while the console must see released buttons

Behaviour:
- Reset values: req_valid=0, req_code=0, req_tmo=0, pad_block=0, state=IDLE, hold_cnt=0, tmo_cnt=0. Reset has priority over every event, including reset in the middle of a request.
- Match function, evaluated only on pad_strobe:
  - A mask matches when the mask is nonzero and pad_val == mask exactly.
  - Priority: menu > save > load.
  - Save and load are eligible only when sst_on=1.
  - The result is a code in 0..3.
- IDLE: on a strobe with match code c != 0, go to MATCH, cand=c, hold_cnt=1. If HOLD_SCANS=1, go directly to FIRE on that same strobe.
- MATCH: evaluated on each strobe.
  - Code == cand: hold_cnt++. When hold_cnt reaches HOLD_SCANS, go to FIRE.
  - Code != cand (including 0): return to IDLE with hold_cnt=0. A different nonzero code is not adopted on this strobe; it can start a new MATCH on a later strobe.
  - Mask registers are read live, so a mask change mid-MATCH takes effect at the next strobe.
- FIRE: entered with req_valid=1, req_code=cand, pad_block=1, tmo_cnt=0. req_valid and req_code are registered and assert in the cycle after the qualifying strobe.
  - req_code stays stable while req_valid=1.
  - req_ack=1 goes to WAIT_REL and clears req_valid and req_code the next cycle.
  - tmo_cnt == ACK_TMO-1 with no ack: go to WAIT_REL and pulse req_tmo for one cycle.
  - Ack and the timeout in the same cycle: the ack wins and req_tmo stays 0.
- WAIT_REL: pad_block stays 1. A strobe with pad_val==0 goes to IDLE, with pad_block falling the next cycle. Any other strobe keeps waiting.
- req_ack outside FIRE is ignored.
- pad_strobe in the same cycle as a state entry is consumed by the transition that was already evaluated; no double counting.
- hold_cnt is 8 bits and saturates; tmo_cnt is 24 bits. Both clear on every state entry.

Decomposition:
- Shared package hotkey_pkg holds:
  - enum HkState {IDLE, MATCH, FIRE, WAIT_REL}
  - the HK_NONE/HK_MENU/HK_SAVE/HK_LOAD code constants
  - the HkReq struct {valid, code}
- One natural sub-module, hk_match: combinational, from masks, pad_val and sst_on to a priority code.
- The FSM and the counters stay in hotkey_ctrl.

Test Plan:
- key_menu=8'h0C, HOLD_SCANS=4, four strobes with pad_val=8'h0C -> req_valid=1, req_code=1 one cycle after the 4th strobe, pad_block=1; ack -> req_valid=0; strobe pad_val=0 -> pad_block=0.
- key_save=8'h81, sst_on=0, six strobes with pad_val=8'h81 -> no request; set sst_on=1, four more strobes -> req_code=2.
- key_save=key_load=8'h41, sst_on=1 -> req_code=2 (save beats load); key_menu=8'h41 as well -> req_code=1.
- Three matching strobes of 8'h0C, then one strobe of 8'h0D, then four of 8'h0C -> exactly one request, fired on the 8th strobe.
- ACK_TMO=16, fire and withhold ack -> req_tmo pulses at cycle 16, req_valid=0, pad_block stays 1 until a zero-button strobe; a late ack is ignored.
- rst asserted in FIRE and in WAIT_REL -> all outputs 0 next cycle; hotkey held through reset re-qualifies only after HOLD_SCANS fresh strobes.

Source files
------------

// File: rtl/hotkey_pkg.sv
// Shared types and code constants for the joypad hotkey controller.
package hotkey_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MATCH,
    FIRE,
    WAIT_REL
  } HkState;

  localparam logic [1:0] HK_NONE = 2'd0;
  localparam logic [1:0] HK_MENU = 2'd1;
  localparam logic [1:0] HK_SAVE = 2'd2;
  localparam logic [1:0] HK_LOAD = 2'd3;

  typedef struct packed {
    logic       valid;
    logic [1:0] code;
  } HkReq;

endpackage

// File: rtl/hk_match.sv
// Combinational hotkey matcher: exact mask compare with menu > save > load priority.
module hk_match
  import hotkey_pkg::*;
(
  input  logic [7:0] pad_val,
  input  logic [7:0] key_save,
  input  logic [7:0] key_load,
  input  logic [7:0] key_menu,
  input  logic       sst_on,
  output logic [1:0] code
);

  // Zero masks are disabled; save/load only count while save-states are on.
  always_comb begin
    code = HK_NONE;
    if (key_menu != '0 && pad_val == key_menu) begin
      code = HK_MENU;
    end else if (sst_on && key_save != '0 && pad_val == key_save) begin
      code = HK_SAVE;
    end else if (sst_on && key_load != '0 && pad_val == key_load) begin
      code = HK_LOAD;
    end
  end

endmodule

// File: rtl/hotkey_ctrl.sv
// Hotkey controller: qualifies a held combo over several scans, raises one
// request to the MCU, waits for ack or timeout, then blocks the pad until release.
module hotkey_ctrl
  import hotkey_pkg::*;
#(
  parameter int unsigned HOLD_SCANS = 4,
  parameter logic [23:0] ACK_TMO    = 24'd1000000,
  parameter int unsigned CODE_W     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        pad_val,
  input  logic              pad_strobe,
  input  logic [7:0]        key_save,
  input  logic [7:0]        key_load,
  input  logic [7:0]        key_menu,
  input  logic              sst_on,
  output logic              req_valid,
  output logic [CODE_W-1:0] req_code,
  input  logic              req_ack,
  output logic              req_tmo,
  output logic              pad_block
);

  HkState      state_q, state_d;
  logic [1:0]  cand_q, cand_d;
  logic [7:0]  hold_cnt_q, hold_cnt_d;
  logic [23:0] tmo_cnt_q, tmo_cnt_d;
  HkReq        req_q, req_d;
  logic        req_tmo_q, req_tmo_d;
  logic        pad_block_q, pad_block_d;

  logic [1:0]  match_code;
  logic [7:0]  hold_inc;
  logic        hold_done;
  logic        fire_go;
  logic [1:0]  fire_code;

  hk_match u_match (
    .pad_val  (pad_val),
    .key_save (key_save),
    .key_load (key_load),
    .key_menu (key_menu),
    .sst_on   (sst_on),
    .code     (match_code)
  );

  // Saturating hold count and qualification threshold.
  always_comb begin
    hold_inc  = (hold_cnt_q == '1) ? hold_cnt_q : hold_cnt_q + 8'd1;
    hold_done = 32'(hold_inc) >= HOLD_SCANS;
  end

  // Next-state logic; entry into FIRE is shared by IDLE (single-scan hold) and MATCH.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    hold_cnt_d  = hold_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    req_d       = req_q;
    req_tmo_d   = 1'b0;
    pad_block_d = pad_block_q;
    fire_go     = 1'b0;
    fire_code   = cand_q;

    case (state_q)
      IDLE: begin
        if (pad_strobe && match_code != HK_NONE) begin
          cand_d = match_code;
          if (HOLD_SCANS <= 1) begin
            fire_go   = 1'b1;
            fire_code = match_code;
          end else begin
            state_d    = MATCH;
            hold_cnt_d = 8'd1;
          end
        end
      end
      MATCH: begin
        if (pad_strobe) begin
          if (match_code == cand_q) begin
            if (hold_done) begin
              fire_go = 1'b1;
            end else begin
              hold_cnt_d = hold_inc;
            end
          end else begin
            state_d    = IDLE;
            hold_cnt_d = '0;
          end
        end
      end
      FIRE: begin
        if (req_ack) begin
          state_d   = WAIT_REL;
          req_d     = '0;
          tmo_cnt_d = '0;
        end else if (tmo_cnt_q == ACK_TMO - 24'd1) begin
          state_d   = WAIT_REL;
          req_d     = '0;
          req_tmo_d = 1'b1;
          tmo_cnt_d = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 24'd1;
        end
      end
      WAIT_REL: begin
        if (pad_strobe && pad_val == '0) begin
          state_d     = IDLE;
          pad_block_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (fire_go) begin
      state_d     = FIRE;
      hold_cnt_d  = '0;
      tmo_cnt_d   = '0;
      req_d.valid = 1'b1;
      req_d.code  = fire_code;
      pad_block_d = 1'b1;
    end
  end

  // State, counters and registered outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cand_q      <= HK_NONE;
      hold_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      req_q       <= '0;
      req_tmo_q   <= 1'b0;
      pad_block_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      hold_cnt_q  <= hold_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      req_q       <= req_d;
      req_tmo_q   <= req_tmo_d;
      pad_block_q <= pad_block_d;
    end
  end

  assign req_valid = req_q.valid;
  assign req_code  = CODE_W'(req_q.code);
  assign req_tmo   = req_tmo_q;
  assign pad_block = pad_block_q;

endmodule

// File: tb/tb_hotkey_ctrl.sv
// Bench for hotkey_ctrl: directed scenarios with literal expectations, then
// randomized scans/acks/resets checked every cycle against a streak-based model.
module tb_hotkey_ctrl;

  localparam int unsigned HOLD = 4;
  localparam logic [23:0] TMO  = 24'd16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pad_val;
  logic       pad_strobe;
  logic [7:0] key_save, key_load, key_menu;
  logic       sst_on;
  logic       req_valid;
  logic [1:0] req_code;
  logic       req_ack;
  logic       req_tmo;
  logic       pad_block;

  int n_vec  = 0;
  int n_miss = 0;

  hotkey_ctrl #(.HOLD_SCANS(HOLD), .ACK_TMO(TMO), .CODE_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .pad_val    (pad_val),
    .pad_strobe (pad_strobe),
    .key_save   (key_save),
    .key_load   (key_load),
    .key_menu   (key_menu),
    .sst_on     (sst_on),
    .req_valid  (req_valid),
    .req_code   (req_code),
    .req_ack    (req_ack),
    .req_tmo    (req_tmo),
    .pad_block  (pad_block)
  );

  always #5 clk = ~clk;

  // Reference: code k+1 for the first enabled mask k (menu, save, load) equal to the pad.
  function automatic logic [1:0] ref_code(input logic [7:0] p, input logic [7:0] m,
                                          input logic [7:0] s, input logic [7:0] l,
                                          input logic en);
    logic [7:0] mk [3];
    mk[0] = m; mk[1] = s; mk[2] = l;
    for (int k = 0; k < 3; k++)
      if (mk[k] != 8'h00 && p == mk[k] && (k == 0 || en)) return 2'(k + 1);
    return 2'd0;
  endfunction

  // Model: streak of identical nonzero codes; request lives for at most TMO cycles.
  int         m_streak, m_wait;
  logic [1:0] m_cand, m_code;
  logic       m_req, m_tmo, m_blk;

  always @(posedge clk) begin : model
    logic [1:0] c;
    c = ref_code(pad_val, key_menu, key_save, key_load, sst_on);
    if (rst) begin
      m_streak = 0; m_wait = 0; m_cand = 2'd0; m_code = 2'd0;
      m_req = 1'b0; m_tmo = 1'b0; m_blk = 1'b0;
    end else begin
      m_tmo = 1'b0;
      if (m_req) begin
        if (req_ack) begin
          m_req = 1'b0; m_code = 2'd0;
        end else if (m_wait == int'(TMO) - 1) begin
          m_req = 1'b0; m_code = 2'd0; m_tmo = 1'b1;
        end else begin
          m_wait++;
        end
      end else if (m_blk) begin
        if (pad_strobe && pad_val == 8'h00) m_blk = 1'b0;
      end else if (pad_strobe) begin
        if (c != 2'd0 && (m_streak == 0 || c == m_cand)) begin
          if (m_streak == 0) m_cand = c;
          m_streak++;
          if (m_streak >= int'(HOLD)) begin
            m_req = 1'b1; m_code = m_cand; m_blk = 1'b1; m_wait = 0; m_streak = 0;
          end
        end else begin
          m_streak = 0;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    n_vec++;
    if ({req_valid, req_code, req_tmo, pad_block} !== {m_req, m_code, m_tmo, m_blk}) begin
      n_miss++;
      $display("FAIL model t=%0t got v=%b code=%0d tmo=%b blk=%b want v=%b code=%0d tmo=%b blk=%b",
               $time, req_valid, req_code, req_tmo, pad_block, m_req, m_code, m_tmo, m_blk);
    end
  end

  task automatic expect_out(input string name, input logic v, input logic [1:0] c,
                            input logic t, input logic b);
    n_vec++;
    if ({req_valid, req_code, req_tmo, pad_block} !== {v, c, t, b}) begin
      n_miss++;
      $display("FAIL %s t=%0t got v=%b code=%0d tmo=%b blk=%b want v=%b code=%0d tmo=%b blk=%b",
               name, $time, req_valid, req_code, req_tmo, pad_block, v, c, t, b);
    end
  endtask

  // All driving tasks start and end just after a falling edge.
  task automatic scan(input logic [7:0] v);
    pad_val = v; pad_strobe = 1'b1;
    @(negedge clk);
    pad_strobe = 1'b0;
  endtask

  task automatic scan_n(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) scan(v);
  endtask

  task automatic ack();
    req_ack = 1'b1;
    @(negedge clk);
    req_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [7:0] pool [5];
  logic [7:0] cur;

  initial begin
    rst = 1'b1; pad_val = 8'h00; pad_strobe = 1'b0; req_ack = 1'b0;
    key_save = 8'h00; key_load = 8'h00; key_menu = 8'h00; sst_on = 1'b0;
    idle(3);
    expect_out("reset", 1'b0, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    idle(1);

    // Menu hotkey: fires after the fourth scan, ack, release.
    key_menu = 8'h0C;
    scan_n(8'h0C, 3);
    expect_out("menu_hold3", 1'b0, 2'd0, 1'b0, 1'b0);
    scan(8'h0C);
    expect_out("menu_fire", 1'b1, 2'd1, 1'b0, 1'b1);
    ack();
    expect_out("menu_ack", 1'b0, 2'd0, 1'b0, 1'b1);
    scan(8'h00);
    expect_out("menu_release", 1'b0, 2'd0, 1'b0, 1'b0);

    // Save gated by sst_on.
    key_menu = 8'h00; key_save = 8'h81;
    scan_n(8'h81, 6);
    expect_out("save_gated", 1'b0, 2'd0, 1'b0, 1'b0);
    sst_on = 1'b1;
    scan_n(8'h81, 4);
    expect_out("save_fire", 1'b1, 2'd2, 1'b0, 1'b1);
    ack(); scan(8'h00);

    // Priority: save beats load, menu beats both.
    key_save = 8'h41; key_load = 8'h41;
    scan_n(8'h41, 4);
    expect_out("save_over_load", 1'b1, 2'd2, 1'b0, 1'b1);
    ack(); scan(8'h00);
    key_menu = 8'h41;
    scan_n(8'h41, 4);
    expect_out("menu_over_save", 1'b1, 2'd1, 1'b0, 1'b1);
    ack(); scan(8'h00);
    key_save = 8'h00; key_load = 8'h00; key_menu = 8'h0C;

    // Broken streak restarts qualification.
    scan_n(8'h0C, 3); scan(8'h0D); scan_n(8'h0C, 3);
    expect_out("streak_broken", 1'b0, 2'd0, 1'b0, 1'b0);
    scan(8'h0C);
    expect_out("streak_8th", 1'b1, 2'd1, 1'b0, 1'b1);
    ack(); scan(8'h00);

    // Timeout after TMO cycles, late ack ignored, block held until release.
    scan_n(8'h0C, 4);
    idle(int'(TMO) - 1);
    expect_out("tmo_last_valid", 1'b1, 2'd1, 1'b0, 1'b1);
    idle(1);
    expect_out("tmo_pulse", 1'b0, 2'd0, 1'b1, 1'b1);
    idle(1);
    expect_out("tmo_one_cycle", 1'b0, 2'd0, 1'b0, 1'b1);
    ack();
    expect_out("late_ack", 1'b0, 2'd0, 1'b0, 1'b1);
    scan(8'h0C);
    expect_out("blk_nonzero_scan", 1'b0, 2'd0, 1'b0, 1'b1);
    scan(8'h00);
    expect_out("tmo_release", 1'b0, 2'd0, 1'b0, 1'b0);

    // Ack on the timeout cycle wins.
    scan_n(8'h0C, 4);
    idle(int'(TMO) - 1);
    ack();
    expect_out("ack_beats_tmo", 1'b0, 2'd0, 1'b0, 1'b1);
    scan(8'h00);

    // Reset in FIRE, re-qualification of a held key, reset in WAIT_REL.
    scan_n(8'h0C, 4);
    rst = 1'b1; idle(1); rst = 1'b0;
    expect_out("rst_in_fire", 1'b0, 2'd0, 1'b0, 1'b0);
    scan_n(8'h0C, 3);
    expect_out("rst_requal3", 1'b0, 2'd0, 1'b0, 1'b0);
    scan(8'h0C);
    expect_out("rst_requal4", 1'b1, 2'd1, 1'b0, 1'b1);
    ack();
    rst = 1'b1; idle(1); rst = 1'b0;
    expect_out("rst_in_wait", 1'b0, 2'd0, 1'b0, 1'b0);
    scan(8'h00);

    // Randomized traffic.
    pool[0] = 8'h0C; pool[1] = 8'h81; pool[2] = 8'h41; pool[3] = 8'h00; pool[4] = 8'h03;
    cur = 8'h00;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) >= 80) begin
        case ($urandom_range(0, 4))
          0: cur = key_menu;
          1: cur = key_save;
          2: cur = key_load;
          3: cur = 8'h00;
          default: cur = 8'($urandom);
        endcase
      end
      pad_val    = cur;
      pad_strobe = ($urandom_range(0, 2) == 0);
      req_ack    = req_valid ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 29) == 0);
      rst        = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 199) == 0) sst_on = ~sst_on;
      if ($urandom_range(0, 299) == 0) begin
        key_menu = pool[$urandom_range(0, 4)];
        key_save = pool[$urandom_range(0, 4)];
        key_load = pool[$urandom_range(0, 4)];
      end
      @(negedge clk);
    end
    rst = 1'b0; pad_strobe = 1'b0; req_ack = 1'b0;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
